rv32_decode_stage: RTL
======================

// Module: rv32_decode_stage
// PURPOSE
//  Registered RV32I instruction decode stage with valid/ready handshake and output buffer.
//  Sits between fetch and execute. Per instruction it produces:
//   - a one-hot instruction flag vector
//   - register indices
//   - a format-selected, sign-extended immediate
//   - an illegal-instruction flag
//  Decoupling is provided by a BUF_DEPTH-entry FIFO.
// PARAMETERS
//  XLEN       32  immediate output width; immediates sign-extended to XLEN (legal: 32, 64)
//  BUF_DEPTH  2   output FIFO entries; power of two, >=2
//  PC_W       32  width of the pc sideband carried with each instruction
// PORTS
//  clk          in   1     single clock, all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     discards all buffered entries and any same-cycle input
//  in_valid     in   1     instruction_code/in_pc valid
//  in_ready     out  1     stage can accept (= !full && !rst)
//  instruction_code in 32  raw instruction word
//  in_pc        in   PC_W  pc of instruction, passed through unchanged
//  out_valid    out  1     decoded entry available (= !empty)
//  out_ready    in   1     consumer takes the head entry
//  out_pc       out  PC_W  pc of head entry
//  inst_flags   out  48    one-hot decode, bit order below
//  rd,rs1,rs2   out  5 ea  instruction[11:7],[19:15],[24:20], raw for every format
//  imm          out  XLEN  decoded immediate per format
//  invalid_instruction out 1  head entry is illegal
// BEHAVIOUR
//  inst_flags bit order, LSB first:
//   lui auipc jal jalr beq bne blt bge bltu bgeu lb lh lw lbu lhu sb sh sw
//   addi slti sltiu xori ori andi slli srli srai add sub sll slt sltu xor srl sra or and
//   fence ecall ebreak csrrw csrrs csrrc csrrwi csrrsi csrrci mret wfi   (bit 47 = wfi)
//  Reset: FIFO emptied, out_valid=0, in_ready=0 while rst high; all data outputs 0.
//  Accept: in_valid && in_ready at edge N -> entry visible (out_valid=1) from edge N+1.
//   - Latency exactly 1 cycle when the FIFO is empty.
//  Pop: out_valid && out_ready at an edge removes the head. Order is strictly FIFO.
//  Simultaneous push+pop:
//   - Allowed when not full; count unchanged.
//   - When full, in_ready=0, so no push, even if a pop occurs that cycle (no combinational ready path).
//  Empty: data outputs hold the last popped values (0 after reset); out_valid=0.
//  Flush: at next edge count=0 and pointers reset; the input in the flush cycle is not accepted.
//   - Flush has priority over push/pop; rst has priority over flush.
//  Decode is combinational on instruction_code and is stored into the FIFO at accept.
//  Imm per format:
//   - I: sext(ins[31:20])
//   - S: sext({ins[31:25],ins[11:7]})
//   - B: sext({ins[31],ins[7],ins[30:25],ins[11:8],0})
//   - U: sext({ins[31:12],12'b0})
//   - J: sext({ins[31],ins[19:12],ins[20],ins[30:21],0})
//   - shifts: zero-extended ins[24:20]
//   - CSR: zero-extended ins[31:20]; uimm is in rs1
//   - R/fence/system: 0
//  Illegal (invalid_instruction=1, inst_flags=0, imm=0) when any of:
//   - ins[1:0]!=2'b11
//   - unknown opcode
//   - unused funct3
//   - funct7 not 0x00/0x20 where it applies
//   - 0x20 on a non-sub/sra/srai op
//   - shift with ins[25]=1
//   - system encoding not listed
//  Otherwise exactly one flag is set. rd/rs1/rs2 are always raw fields, including for illegal entries.
//  Pointers wrap modulo BUF_DEPTH; count width is clog2(BUF_DEPTH)+1.
// CONFIGURATION
//  DECODE_ZICSR_EN defined:
//   - csrrw..csrrci, mret and wfi are decoded.
//  DECODE_ZICSR_EN undefined:
//   - those encodings flag illegal and flag bits 40..47 are tied 0.
//   - ecall/ebreak/fence are still decoded.
// TESTING
//  1 addi: 0x00500093, out_ready=1
//     -> next cycle out_valid=1, addi flag (bit18)=1, rd=1, rs1=0, imm=5, invalid=0.
//  2 lui then beq back-to-back: 0x12345137, 0xFE208EE3
//     -> imm=0x12345000 (rd=2) then imm=0xFFFFFFFC (rs1=1, rs2=2), beq bit4.
//  3 Illegal words 0x00000000 and 0x02005013 (srli, funct7=1)
//     -> invalid=1, inst_flags=0, imm=0.
//  4 Backpressure: out_ready=0, push 3 words (BUF_DEPTH=2)
//     -> in_ready=0 after 2 accepts, 3rd held.
//     -> Release out_ready: three words emerge in order with their pcs.
//  5 Flush with 2 entries buffered and in_valid=1
//     -> next cycle out_valid=0, in_ready=1, flushed-cycle word never appears.
//     -> rst mid-stream gives the same result, plus in_ready=0 during rst.
//  6 csrrw 0x300110F3
//     -> with DECODE_ZICSR_EN: bit40=1, rd=1, rs1=2, imm=0x300.
//     -> without DECODE_ZICSR_EN: invalid=1, flags=0.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32I decoder feeding a BUF_DEPTH-entry output FIFO.
// Define DECODE_ZICSR_EN to also decode csrrw..csrrci, mret and wfi.
module rv32_decode_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_code,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [47:0]     inst_flags,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            invalid_instruction
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [47:0]     flags;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [47:0]     dflags;
    logic [XLEN-1:0] dimm;
    logic            dill;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;
    entry_t          dec;

    assign ins = instruction_code;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    assign imm_i   = XLEN'($signed(ins[31:20]));
    assign imm_s   = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b   = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({ins[31:12], 12'b0}));
    assign imm_j   = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    assign imm_sh  = XLEN'(ins[24:20]);
    assign imm_csr = XLEN'(ins[31:20]);

    // An encoding is illegal exactly when no flag gets set below.
    always_comb begin
        dflags = '0;
        dimm   = '0;
        case (opc)
            7'b0110111: begin dflags[0] = 1'b1; dimm = imm_u; end
            7'b0010111: begin dflags[1] = 1'b1; dimm = imm_u; end
            7'b1101111: begin dflags[2] = 1'b1; dimm = imm_j; end
            7'b1100111: begin dflags[3] = (f3 == 3'b000); dimm = imm_i; end
            7'b1100011: begin
                dimm = imm_b;
                case (f3)
                    3'b000:  dflags[4] = 1'b1;
                    3'b001:  dflags[5] = 1'b1;
                    3'b100:  dflags[6] = 1'b1;
                    3'b101:  dflags[7] = 1'b1;
                    3'b110:  dflags[8] = 1'b1;
                    3'b111:  dflags[9] = 1'b1;
                    default: ;
                endcase
            end
            7'b0000011: begin
                dimm = imm_i;
                case (f3)
                    3'b000:  dflags[10] = 1'b1;
                    3'b001:  dflags[11] = 1'b1;
                    3'b010:  dflags[12] = 1'b1;
                    3'b100:  dflags[13] = 1'b1;
                    3'b101:  dflags[14] = 1'b1;
                    default: ;
                endcase
            end
            7'b0100011: begin
                dimm = imm_s;
                case (f3)
                    3'b000:  dflags[15] = 1'b1;
                    3'b001:  dflags[16] = 1'b1;
                    3'b010:  dflags[17] = 1'b1;
                    default: ;
                endcase
            end
            7'b0010011: begin
                dimm = imm_i;
                case (f3)
                    3'b000: dflags[18] = 1'b1;
                    3'b010: dflags[19] = 1'b1;
                    3'b011: dflags[20] = 1'b1;
                    3'b100: dflags[21] = 1'b1;
                    3'b110: dflags[22] = 1'b1;
                    3'b111: dflags[23] = 1'b1;
                    3'b001: begin
                        dimm       = imm_sh;
                        dflags[24] = (f7 == 7'h00);
                    end
                    default: begin
                        dimm       = imm_sh;
                        dflags[25] = (f7 == 7'h00);
                        dflags[26] = (f7 == 7'h20);
                    end
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dflags[27] = 1'b1;
                        3'b001:  dflags[29] = 1'b1;
                        3'b010:  dflags[30] = 1'b1;
                        3'b011:  dflags[31] = 1'b1;
                        3'b100:  dflags[32] = 1'b1;
                        3'b101:  dflags[33] = 1'b1;
                        3'b110:  dflags[35] = 1'b1;
                        default: dflags[36] = 1'b1;
                    endcase
                end else if (f7 == 7'h20) begin
                    dflags[28] = (f3 == 3'b000);
                    dflags[34] = (f3 == 3'b101);
                end
            end
            7'b0001111: dflags[37] = (f3 == 3'b000);
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    case (ins)
                        32'h0000_0073: dflags[38] = 1'b1;
                        32'h0010_0073: dflags[39] = 1'b1;
`ifdef DECODE_ZICSR_EN
                        32'h3020_0073: dflags[46] = 1'b1;
                        32'h1050_0073: dflags[47] = 1'b1;
`endif
                        default: ;
                    endcase
                end else begin
`ifdef DECODE_ZICSR_EN
                    dimm = imm_csr;
                    case (f3)
                        3'b001:  dflags[40] = 1'b1;
                        3'b010:  dflags[41] = 1'b1;
                        3'b011:  dflags[42] = 1'b1;
                        3'b101:  dflags[43] = 1'b1;
                        3'b110:  dflags[44] = 1'b1;
                        3'b111:  dflags[45] = 1'b1;
                        default: ;
                    endcase
`else
                    dimm = imm_csr;
`endif
                end
            end
            default: ;
        endcase
        dill = ~|dflags;
        if (dill) begin
            dimm = '0;
        end
    end

    assign dec = '{pc: in_pc, flags: dflags, rd: ins[11:7], rs1: ins[19:15],
                   rs2: ins[24:20], imm: dimm, ill: dill};

    entry_t        mem_q [BUF_DEPTH];
    entry_t        mem_d [BUF_DEPTH];
    entry_t        last_q, last_d, head, view;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    assign full      = (count_q == CW'(BUF_DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty && !rst;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                last_d   = head;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
        mem_q <= mem_d;
    end

    // With nothing buffered the outputs keep showing the last consumed entry.
    assign view = rst ? '0 : (empty ? last_q : head);

    assign out_pc              = view.pc;
    assign inst_flags          = view.flags;
    assign rd                  = view.rd;
    assign rs1                 = view.rs1;
    assign rs2                 = view.rs2;
    assign imm                 = view.imm;
    assign invalid_instruction = view.ill;
endmodule
